// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: per-stage hazard inputs from the pipeline and the
// enables, flushes and counters returned by the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_redirect;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  cnt_clr;

    logic                  pc_en;
    logic                  if_id_en;
    logic                  if_id_flush;
    logic                  id_ex_en;
    logic                  id_ex_flush;
    logic                  ex_mem_en;
    logic                  mem_wb_bubble;
    logic                  mem_err;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_redirect, mem_req, mem_ready, cnt_clr,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_bubble, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_redirect, mem_req, mem_ready, cnt_clr,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_bubble, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirects,
// data-memory wait freezes with timeout, and saturating stall/flush counters.
//
// state       | meaning
// ST_RUN      | normal flow; redirect / load-use resolved combinationally
// ST_MEM_WAIT | data memory busy, pipeline frozen, wait_cnt counting
// ST_ERROR    | memory timed out, permanent freeze until Reset
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic                   clk,
    input logic                   Reset,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]  stall_q, flush_q;
    logic              memwait, loaduse, freeze, resolve, redirect_taken;
    logic              pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic              ex_mem_en, mem_wb_bubble;

    assign memwait = hz.mem_req & ~hz.mem_ready;
    assign loaduse = hz.ex_mem_read && (hz.ex_rd != REG_ADDR_W'(0)) &&
                     ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                      (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        freeze         = 1'b0;
        resolve        = 1'b0;
        redirect_taken = 1'b0;
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_en       = 1'b1;
        id_ex_flush    = 1'b0;
        ex_mem_en      = 1'b1;
        mem_wb_bubble  = 1'b0;

        case (state)
            ST_RUN: begin
                if (memwait) begin
                    freeze       = 1'b1;
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end else begin
                    resolve = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // A dropped mem_req is treated the same as mem_ready.
                if (memwait) begin
                    freeze       = 1'b1;
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_cnt == WAIT_LAST) state_nxt = ST_ERROR;
                end else begin
                    resolve      = 1'b1;
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end
            end
            ST_ERROR: freeze = 1'b1;
            default: begin
                freeze    = 1'b1;
                state_nxt = ST_RUN;
            end
        endcase

        if (resolve) begin
            if (hz.ex_redirect) begin
                redirect_taken = 1'b1;
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
            end else if (loaduse) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        if (freeze) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end

        // Reset holds every stage and injects bubbles everywhere.
        if (Reset) begin
            redirect_taken = 1'b0;
            pc_en          = 1'b0;
            if_id_en       = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_en       = 1'b0;
            id_ex_flush    = 1'b1;
            ex_mem_en      = 1'b0;
            mem_wb_bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (hz.cnt_clr)
                stall_q <= '0;
            else if (!pc_en && (stall_q != CNT_MAX))
                stall_q <= stall_q + CNT_W'(1);
            if (hz.cnt_clr)
                flush_q <= '0;
            else if (redirect_taken && (flush_q != CNT_MAX))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.pc_en         = pc_en;
    assign hz.if_id_en      = if_id_en;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_en      = id_ex_en;
    assign hz.id_ex_flush   = id_ex_flush;
    assign hz.ex_mem_en     = ex_mem_en;
    assign hz.mem_wb_bubble = mem_wb_bubble;
    assign hz.mem_err       = (state == ST_ERROR);
    assign hz.stall_cnt     = stall_q;
    assign hz.flush_cnt     = flush_q;
endmodule
